// File: rtl/parity_arb_pkg.sv
// Shared constants and helpers for the parity unit arbiter.
package parity_arb_pkg;

    // Width of each requester word fed to the parity unit.
    localparam int PAR_DATA_W = 4;

    // Width needed to index n requesters; never below 1 bit.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/parity_unit_arbiter_odd_parity4.sv
// Combinational 4-input odd-parity unit: out=1 when an odd number of inputs are set.
module odd_parity4
    import parity_arb_pkg::*;
(
    input  logic in0,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    output logic out
);

    assign out = in0 ^ in1 ^ in2 ^ in3;

endmodule

// File: rtl/parity_unit_arbiter.sv
// Round-robin arbiter sharing one odd-parity unit among NREQ requesters.
// The result is registered with the requester index on a valid/ready port.
// Optional build macro PARITY_ARB_STATS_EN adds a saturating odd-result counter.
module parity_unit_arbiter
    import parity_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [PAR_DATA_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]              req_ready,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [IDW-1:0]               rsp_id,
    output logic                         rsp_odd,
    output logic [CNTW-1:0]              odd_count
);

    logic [IDW-1:0]        rr_ptr;
    logic                  grant_vld_p0;
    logic [IDW-1:0]        grant_idx_p0;
    logic [IDW-1:0]        rr_next_p0;
    logic [PAR_DATA_W-1:0] word_p0;
    logic                  odd_p0;
    logic                  can_load_p0;
    logic                  xfer_p0;

    logic                  vld_p1;
    logic [IDW-1:0]        id_p1;
    logic                  odd_p1;

    // ---- Stage p0: arbitration, word mux, parity ----

    // Scan requesters starting at rr_ptr, wrapping, and pick the first valid one.
    always_comb begin
        grant_vld_p0 = 1'b0;
        grant_idx_p0 = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_vld_p0 && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                grant_vld_p0 = 1'b1;
                grant_idx_p0 = IDW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    // The response register can take a new result when empty or being drained.
    assign can_load_p0 = !vld_p1 || rsp_ready;
    assign xfer_p0     = grant_vld_p0 && can_load_p0;
    assign word_p0     = req_data[PAR_DATA_W*grant_idx_p0 +: PAR_DATA_W];
    assign rr_next_p0  = (grant_idx_p0 == IDW'(NREQ-1)) ? '0 : grant_idx_p0 + 1'b1;

    // One-hot ready to the winner only when the transfer can actually land.
    always_comb begin
        req_ready = '0;
        if (xfer_p0) begin
            req_ready[grant_idx_p0] = 1'b1;
        end
    end

    odd_parity4 u_parity (
        .in0 (word_p0[0]),
        .in1 (word_p0[1]),
        .in2 (word_p0[2]),
        .in3 (word_p0[3]),
        .out (odd_p0)
    );

    // ---- Stage p1: response register and round-robin pointer ----

    // Load on transfer, drain when consumed, hold under backpressure; reset drops any held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            id_p1  <= '0;
            odd_p1 <= 1'b0;
            rr_ptr <= '0;
        end else if (xfer_p0) begin
            vld_p1 <= 1'b1;
            id_p1  <= grant_idx_p0;
            odd_p1 <= odd_p0;
            rr_ptr <= rr_next_p0;
        end else if (rsp_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_id    = id_p1;
    assign rsp_odd   = odd_p1;

`ifdef PARITY_ARB_STATS_EN
    logic [CNTW-1:0] cnt_p1;

    // Increment that sticks at the all-ones maximum instead of wrapping.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Count every result loaded with odd parity, saturating at the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p1 <= '0;
        end else if (xfer_p0 && odd_p0) begin
            cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign odd_count = cnt_p1;
`else
    assign odd_count = '0;
`endif

endmodule

// File: tb/tb_parity_unit_arbiter.sv
// Self-checking bench for parity_unit_arbiter (NREQ=4, CNTW=2): vector table,
// scoreboard of expected responses and hand sequences for backpressure/reset/stats.
module tb_parity_unit_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_odd;
    logic [CNTW-1:0]   odd_count;

    parity_unit_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_odd   (rsp_odd),
        .odd_count (odd_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] id;
        logic       odd;
    } rsp_t;

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] data;
        logic [3:0]  exp_rdy;
    } vec_t;

    rsp_t       exp_q[$];
    vec_t       tbl[8];
    int         checks = 0;
    int         errors = 0;
    int         m_ptr;
    logic       m_vld;
    int         m_cnt;
    logic [3:0] seen_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_vld = 1'b0;
        m_cnt = 0;
        exp_q.delete();
    endtask

    // One clock: check outputs against the model at negedge, then advance model over the edge.
    task automatic cycle();
        logic       can;
        int         g;
        logic [3:0] exp_rdy;
        logic [3:0] w;
        rsp_t       r;
        @(negedge clk);
        can = !m_vld || rsp_ready;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        end
        exp_rdy = '0;
        if (can && g >= 0) exp_rdy[g] = 1'b1;
        seen_rdy = req_ready;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_vld));
        chk("odd_count", 32'(odd_count), 32'(m_cnt));
        if (m_vld) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
                chk("rsp_odd", 32'(rsp_odd), 32'(exp_q[0].odd));
                if (rsp_ready && !rst) void'(exp_q.pop_front());
            end
        end
        if (rst) begin
            model_reset();
        end else if (can && g >= 0) begin
            w = req_data[4*g +: 4];
            r.id  = 2'(g);
            r.odd = ^w;
            exp_q.push_back(r);
            m_ptr = (g == NREQ-1) ? 0 : g + 1;
            m_vld = 1'b1;
`ifdef PARITY_ARB_STATS_EN
            if (r.odd && m_cnt != (1 << CNTW) - 1) m_cnt++;
`endif
        end else if (rsp_ready) begin
            m_vld = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] grant_seq[5];
        logic       odd_seq[5];
        logic [3:0] bp_seq[3];
        int         cnt_seq[5];
        logic [1:0] held_id;
        logic       held_odd;

        // Table starts from rr_ptr=0 with rsp_ready=1 throughout.
        tbl[0] = '{4'b0100, 16'h0700, 4'b0100}; // ptr 0 -> 2, ptr becomes 3
        tbl[1] = '{4'b0011, 16'h0031, 4'b0001}; // ptr 3 wraps to 0, ptr 1
        tbl[2] = '{4'b1001, 16'hF00E, 4'b1000}; // ptr 1 -> 3, ptr 0
        tbl[3] = '{4'b0000, 16'h1234, 4'b0000}; // idle, ptr 0
        tbl[4] = '{4'b1110, 16'h5A60, 4'b0010}; // ptr 0 -> 1, ptr 2
        tbl[5] = '{4'b0010, 16'h00B0, 4'b0010}; // ptr 2 wraps to 1, ptr 2
        tbl[6] = '{4'b1111, 16'h8421, 4'b0100}; // ptr 2 -> 2, ptr 3
        tbl[7] = '{4'b1111, 16'h7EC3, 4'b1000}; // ptr 3 -> 3, ptr 0

        grant_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        odd_seq   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        bp_seq    = '{4'b0010, 4'b0100, 4'b1000};
`ifdef PARITY_ARB_STATS_EN
        cnt_seq   = '{1, 2, 3, 3, 3};
`else
        cnt_seq   = '{0, 0, 0, 0, 0};
`endif

        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        rsp_ready = 1'b1;
        do_reset();

        // Reset then idle for 5 cycles.
        repeat (5) cycle();

        // Only requester 2 valid with 0111.
        req_valid = 4'b0100;
        req_data  = 16'h0700;
        cycle();
        chk("t2_ready", 32'(seen_rdy), 32'b0100);
        chk("t2_valid", 32'(rsp_valid), 32'd1);
        chk("t2_id", 32'(rsp_id), 32'd2);
        chk("t2_odd", 32'(rsp_odd), 32'd1);
        req_valid = '0;
        cycle();

        // Table of grant patterns from a fresh pointer.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            req_valid = tbl[i].valid;
            req_data  = tbl[i].data;
            cycle();
            chk($sformatf("tbl%0d_ready", i), 32'(seen_rdy), 32'(tbl[i].exp_rdy));
        end
        req_valid = '0;
        cycle();

        // All four valid: grants rotate 0,1,2,3,0.
        do_reset();
        req_valid = 4'b1111;
        req_data  = {4'b1111, 4'b0111, 4'b0011, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk($sformatf("rot%0d_grant", i), 32'(seen_rdy), 32'(grant_seq[i]));
            chk($sformatf("rot%0d_odd", i), 32'(rsp_odd), 32'(odd_seq[i]));
        end

        // Backpressure for 3 cycles: no grant, response held.
        rsp_ready = 1'b0;
        held_id  = rsp_id;
        held_odd = rsp_odd;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_ready", 32'(seen_rdy), 32'd0);
            chk("bp_id", 32'(rsp_id), 32'(held_id));
            chk("bp_odd", 32'(rsp_odd), 32'(held_odd));
            chk("bp_valid", 32'(rsp_valid), 32'd1);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("resume%0d_grant", i), 32'(seen_rdy), 32'(bp_seq[i]));
        end
        req_valid = '0;
        cycle();

        // Reset while a result is held and requesters are waiting.
        do_reset();
        req_valid = 4'b0010;
        req_data  = 16'h00F0;
        cycle();
        chk("rst_pre_valid", 32'(rsp_valid), 32'd1);
        req_valid = 4'b1010;
        rsp_ready = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_odd", 32'(rsp_odd), 32'd0);
        rsp_ready = 1'b1;
        cycle();
        chk("rst_first_grant", 32'(seen_rdy), 32'b0010);
        req_valid = '0;
        cycle();

        // Five odd results in a row for the counter.
        do_reset();
        req_valid = 4'b0001;
        req_data  = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk($sformatf("cnt%0d", i), 32'(odd_count), 32'(cnt_seq[i]));
        end
        req_valid = '0;
        cycle();
        cycle();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
